// File: rtl/mult_pkg.sv
// Shared types and constants for the 16x16 sequential multiplier controller.
// Shift amounts are expressed in half-word units of the core operand width.
package mult_pkg;

    localparam int MULT_HALF_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    typedef logic [1:0] step_t;

    localparam step_t STEP_FIRST = 2'd0;
    localparam step_t STEP_LAST  = 2'd3;

    localparam int unsigned SH_LL = 0;
    localparam int unsigned SH_LH = 1;
    localparam int unsigned SH_HL = 1;
    localparam int unsigned SH_HH = 2;

    function automatic int unsigned step_shift(step_t s);
        int unsigned sh;
        sh = SH_LL;
        unique case (s)
            2'd0: sh = SH_LL;
            2'd1: sh = SH_LH;
            2'd2: sh = SH_HL;
            2'd3: sh = SH_HH;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mult16_seq_ctrl_if.sv
// Operand/result handshakes plus the external 8x8 core connection.
// slave is the controller side, master is the source/sink/core side.
interface mult16_seq_ctrl_if
    import mult_pkg::*;
#(
    parameter int HALF_W = MULT_HALF_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*HALF_W-1:0]   A;
    logic [2*HALF_W-1:0]   B;
    logic [HALF_W-1:0]     core_X;
    logic [HALF_W-1:0]     core_Y;
    logic [2*HALF_W-1:0]   core_P;
    logic                  res_valid;
    logic                  res_ready;
    logic [4*HALF_W-1:0]   P;
    logic                  busy;

    modport slave (
        input  in_valid,
        output in_ready,
        input  A,
        input  B,
        output core_X,
        output core_Y,
        input  core_P,
        output res_valid,
        input  res_ready,
        output P,
        output busy
    );

    modport master (
        output in_valid,
        input  in_ready,
        output A,
        output B,
        input  core_X,
        input  core_Y,
        output core_P,
        input  res_valid,
        output res_ready,
        input  P,
        input  busy
    );

endinterface

// File: rtl/mult_acc_unit.sv
// Shift-add accumulator for the four partial products.
// The shift depends only on the step index; width leaves room for the full product.
module mult_acc_unit
    import mult_pkg::*;
#(
    parameter int HALF_W = MULT_HALF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_add,
    input  step_t               i_step,
    input  logic [2*HALF_W-1:0] i_core_p,
    output logic [4*HALF_W-1:0] o_acc
);

    logic [4*HALF_W-1:0] r_acc;
    logic [4*HALF_W-1:0] w_ext;
    logic [4*HALF_W-1:0] w_shifted;

    assign w_ext     = {{(2*HALF_W){1'b0}}, i_core_p};
    assign w_shifted = w_ext << (HALF_W * step_shift(i_step));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + w_shifted;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequencer for a 16x16 product using one external 8x8 core over four steps.
// Each step holds the operands CORE_LAT+1 cycles and accumulates on the last.
module mult16_seq_ctrl
    import mult_pkg::*;
#(
    parameter int HALF_W   = MULT_HALF_W,
    parameter int CORE_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    mult16_seq_ctrl_if.slave  bus
);

    localparam logic [1:0] LAT = 2'(CORE_LAT);

    state_t              r_state;
    step_t               r_step;
    logic [1:0]          r_wait;
    logic [2*HALF_W-1:0] r_a;
    logic [2*HALF_W-1:0] r_b;
    logic [HALF_W-1:0]   r_x;
    logic [HALF_W-1:0]   r_y;
    logic                r_in_ready;
    logic                r_res_valid;
    logic                r_busy;

    logic                w_accept;
    logic                w_step_end;
    step_t               w_step_nxt;
    logic [HALF_W-1:0]   w_x_nxt;
    logic [HALF_W-1:0]   w_y_nxt;
    logic [4*HALF_W-1:0] w_acc;

    assign w_accept   = (r_state == IDLE) && bus.in_valid && r_in_ready;
    assign w_step_end = (r_state == MUL) && (r_wait == LAT);
    assign w_step_nxt = r_step + 2'd1;

    // step bit1 picks the A half, bit0 picks the B half
    always_comb begin
        w_x_nxt = r_a[HALF_W-1:0];
        w_y_nxt = r_b[HALF_W-1:0];
        if (w_step_nxt[1]) w_x_nxt = r_a[2*HALF_W-1:HALF_W];
        if (w_step_nxt[0]) w_y_nxt = r_b[2*HALF_W-1:HALF_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_step      <= STEP_FIRST;
            r_wait      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a        <= bus.A;
                        r_b        <= bus.B;
                        r_x        <= bus.A[HALF_W-1:0];
                        r_y        <= bus.B[HALF_W-1:0];
                        r_step     <= STEP_FIRST;
                        r_wait     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MUL;
                    end
                end
                MUL: begin
                    if (w_step_end) begin
                        r_wait <= '0;
                        if (r_step == STEP_LAST) begin
                            r_x         <= '0;
                            r_y         <= '0;
                            r_res_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_step <= w_step_nxt;
                            r_x    <= w_x_nxt;
                            r_y    <= w_y_nxt;
                        end
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_step      <= STEP_FIRST;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mult_acc_unit #(
        .HALF_W (HALF_W)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_accept),
        .i_add    (w_step_end),
        .i_step   (r_step),
        .i_core_p (bus.core_P),
        .o_acc    (w_acc)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.busy      = r_busy;
    assign bus.core_X    = r_x;
    assign bus.core_Y    = r_y;
    // accumulator is only exposed while the result is offered
    assign bus.P         = r_res_valid ? w_acc : '0;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Directed and random checks of the sequential multiplier controller.
// Two instances: a combinational core and a 2-stage pipelined core.
module tb_mult16_seq_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    mult16_seq_ctrl_if #(.HALF_W(8)) if0 ();
    mult16_seq_ctrl_if #(.HALF_W(8)) if2 ();

    mult16_seq_ctrl #(.HALF_W(8), .CORE_LAT(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    mult16_seq_ctrl #(.HALF_W(8), .CORE_LAT(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    logic [15:0] p1;
    logic [15:0] p2;

    assign if0.core_P = {8'h00, if0.core_X} * {8'h00, if0.core_Y};

    always @(posedge clk) begin
        p1 <= {8'h00, if2.core_X} * {8'h00, if2.core_Y};
        p2 <= p1;
    end
    assign if2.core_P = p2;

    always #5 clk = ~clk;

    logic [7:0] xs0 [4] = '{8'h34, 8'h34, 8'h12, 8'h12};
    logic [7:0] ys0 [4] = '{8'h78, 8'h56, 8'h78, 8'h56};
    logic [7:0] xs2 [4] = '{8'hCD, 8'hCD, 8'hAB, 8'hAB};
    logic [7:0] ys2 [4] = '{8'h57, 8'h13, 8'h57, 8'h13};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op0(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string tag);
        int n;
        if0.res_ready = 1'b1;
        if0.in_valid  = 1'b1;
        if0.A = a;
        if0.B = b;
        tick();
        if0.in_valid = 1'b0;
        if0.A = ~a;
        if0.B = ~b;
        n = 1;
        while (!if0.res_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd5);
        chk({tag, "_P"}, 64'(if0.P), 64'(exp));
        tick();
        chk({tag, "_rdy"}, 64'(if0.in_ready), 64'd1);
    endtask

    initial begin
        int n;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] rexp;
        logic [31:0] psnap;
        logic        hs;
        logic        rdy;
        int          n_res;

        clk   = 1'b0;
        rst_n = 1'b0;
        n_chk = 0;
        n_err = 0;
        if0.in_valid = 0; if0.A = 0; if0.B = 0; if0.res_ready = 0;
        if2.in_valid = 0; if2.A = 0; if2.B = 0; if2.res_ready = 0;

        tick();
        tick();
        chk("rst_in_ready", 64'(if0.in_ready), 64'd1);
        chk("rst_res_valid", 64'(if0.res_valid), 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);
        chk("rst_P", 64'(if0.P), 64'd0);
        chk("rst_x", 64'(if0.core_X), 64'd0);
        chk("rst_y", 64'(if0.core_Y), 64'd0);
        rst_n = 1'b1;
        tick();

        // operand sequence and latency on the combinational core
        if0.res_ready = 1'b1;
        if0.in_valid  = 1'b1;
        if0.A = 16'h1234;
        if0.B = 16'h5678;
        tick();
        if0.in_valid = 1'b0;
        if0.A = 16'hDEAD;
        if0.B = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq_x%0d", i), 64'(if0.core_X), 64'(xs0[i]));
            chk($sformatf("seq_y%0d", i), 64'(if0.core_Y), 64'(ys0[i]));
            chk($sformatf("seq_rv%0d", i), 64'(if0.res_valid), 64'd0);
            chk($sformatf("seq_busy%0d", i), 64'(if0.busy), 64'd1);
            tick();
        end
        chk("seq_rv", 64'(if0.res_valid), 64'd1);
        chk("seq_P", 64'(if0.P), 64'h06260060);
        chk("seq_rdy_done", 64'(if0.in_ready), 64'd0);
        tick();
        chk("seq_rdy", 64'(if0.in_ready), 64'd1);
        chk("seq_rv_off", 64'(if0.res_valid), 64'd0);

        do_op0(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "ffff");
        do_op0(16'h0000, 16'hBEEF, 32'h00000000, "zero");
        do_op0(16'h0001, 16'hFFFF, 32'h0000FFFF, "one");

        // result stall with in_valid held high
        if0.res_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.A = 16'h1234;
        if0.B = 16'h5678;
        tick();
        if0.in_valid = 1'b0;
        n = 0;
        while (!if0.res_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            if0.in_valid = 1'b1;
            if0.A = 16'hFFFF;
            if0.B = 16'hFFFF;
            chk($sformatf("stall_P%0d", i), 64'(if0.P), 64'h06260060);
            chk($sformatf("stall_rv%0d", i), 64'(if0.res_valid), 64'd1);
            chk($sformatf("stall_rdy%0d", i), 64'(if0.in_ready), 64'd0);
            tick();
        end
        if0.in_valid  = 1'b0;
        if0.res_ready = 1'b1;
        tick();
        chk("rel_rdy", 64'(if0.in_ready), 64'd1);
        chk("rel_rv", 64'(if0.res_valid), 64'd0);
        chk("rel_busy", 64'(if0.busy), 64'd0);

        // asynchronous abort during step2
        if0.in_valid = 1'b1;
        if0.A = 16'h1234;
        if0.B = 16'h5678;
        tick();
        if0.in_valid = 1'b0;
        tick();
        tick();
        chk("ab_x", 64'(if0.core_X), 64'h12);
        chk("ab_y", 64'(if0.core_Y), 64'h78);
        rst_n = 1'b0;
        #1;
        chk("ab_rdy", 64'(if0.in_ready), 64'd1);
        chk("ab_rv", 64'(if0.res_valid), 64'd0);
        chk("ab_busy", 64'(if0.busy), 64'd0);
        chk("ab_P", 64'(if0.P), 64'd0);
        chk("ab_x0", 64'(if0.core_X), 64'd0);
        chk("ab_y0", 64'(if0.core_Y), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op0(16'h0003, 16'h0005, 32'h0000000F, "post_rst");

        // pipelined core, 3 cycles per step
        if2.res_ready = 1'b1;
        if2.in_valid  = 1'b1;
        if2.A = 16'hABCD;
        if2.B = 16'h1357;
        tick();
        if2.in_valid = 1'b0;
        if2.A = 16'h0000;
        if2.B = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("l2_x%0d", i), 64'(if2.core_X), 64'(xs2[i/3]));
            chk($sformatf("l2_y%0d", i), 64'(if2.core_Y), 64'(ys2[i/3]));
            if (i == 11)
                chk("l2_rv_early", 64'(if2.res_valid), 64'd0);
            tick();
        end
        chk("l2_rv", 64'(if2.res_valid), 64'd1);
        chk("l2_P", 64'(if2.P), 64'h0CFA99AB);
        tick();
        chk("l2_rdy", 64'(if2.in_ready), 64'd1);

        // random operands with random result stalls
        n_res = 0;
        for (int k = 0; k < 200; k++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rexp = {16'h0, ra} * {16'h0, rb};
            if0.in_valid = 1'b1;
            if0.A = ra;
            if0.B = rb;
            n = 0;
            rdy = 1'b0;
            while (!rdy && n < 100) begin
                rdy = if0.in_ready;
                if0.res_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            if0.in_valid = 1'b0;
            if (!rdy) begin
                chk($sformatf("rnd_acc_to%0d", k), 64'd0, 64'd1);
                break;
            end
            n  = 0;
            hs = 1'b0;
            psnap = '0;
            while (!hs && n < 200) begin
                if0.res_ready = 1'($urandom_range(0, 1));
                hs    = if0.res_valid && if0.res_ready;
                psnap = if0.P;
                tick();
                n++;
            end
            if (hs) n_res++;
            chk($sformatf("rnd_P%0d", k), 64'(psnap), 64'(rexp));
            if (!hs) break;
        end
        chk("rnd_count", 64'(n_res), 64'd200);
        tick();
        chk("rnd_idle_rv", 64'(if0.res_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
